// File: rtl/y86_pkg.sv
// Shared Y-86 encodings: icodes, register-ID sentinel, one-hot status values and
// the control half of the D->E pipeline register with its bubble value.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    typedef struct packed {
        logic [3:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] srca;
        logic [3:0] srcb;
        logic [3:0] deste;
        logic [3:0] destm;
    } d2e_ctl_t;

    localparam d2e_ctl_t BUBBLE_CTL = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        srca:  RNONE,
        srcb:  RNONE,
        deste: RNONE,
        destm: RNONE
    };

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two combinational reads, two writes (M beats E on the same ID).
// Latency: writes visible the cycle after the edge; no backpressure, writes always accepted.
module y86_regfile #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 15,
    parameter int RSP_ID   = 4,
    parameter int RSP_INIT = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            rd_a_id,
    input  logic [3:0]            rd_b_id,
    output logic [XLEN-1:0]       rd_a_val,
    output logic [XLEN-1:0]       rd_b_val,
    input  logic [3:0]            wr_e_id,
    input  logic [XLEN-1:0]       wr_e_val,
    input  logic [3:0]            wr_m_id,
    input  logic [XLEN-1:0]       wr_m_val,
    output logic [NREGS*XLEN-1:0] reg_flat
);

    logic [XLEN-1:0] regs [NREGS];

    // IDs outside 0..NREGS-1 (including RNONE) match no entry, so they are dropped on write and read as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == RSP_ID) ? XLEN'(RSP_INIT) : '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_m_id == 4'(i)) begin
                    regs[i] <= wr_m_val;
                end else if (wr_e_id == 4'(i)) begin
                    regs[i] <= wr_e_val;
                end
            end
        end
    end

    always_comb begin
        rd_a_val = '0;
        rd_b_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_a_id == 4'(i)) rd_a_val = regs[i];
            if (rd_b_id == 4'(i)) rd_b_val = regs[i];
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign reg_flat[g*XLEN +: XLEN] = regs[g];
    end

endmodule

// File: rtl/y86_decode_wb_stage.sv
// Y-86 decode/write-back stage: decode, operand forwarding, register file, D->E register; DECODE_PERF_EN adds perf counters.
// Latency: 1 cycle D->E; backpressure: E_stall holds the E register, E_bubble (dominant) inserts a nop.
module y86_decode_wb_stage
    import y86_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NREGS    = 15,
    parameter int RSP_ID   = 4,
    parameter int RSP_INIT = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            D_stat,
    input  logic [3:0]            D_icode,
    input  logic [3:0]            D_ifun,
    input  logic [3:0]            D_rA,
    input  logic [3:0]            D_rB,
    input  logic [XLEN-1:0]       D_valC,
    input  logic [XLEN-1:0]       D_valP,
    input  logic                  E_stall,
    input  logic                  E_bubble,
    input  logic [3:0]            e_destE,
    input  logic [XLEN-1:0]       e_valE,
    input  logic [3:0]            M_destE,
    input  logic [XLEN-1:0]       M_valE,
    input  logic [3:0]            M_destM,
    input  logic [XLEN-1:0]       m_valM,
    input  logic [3:0]            W_destE,
    input  logic [XLEN-1:0]       W_valE,
    input  logic [3:0]            W_destM,
    input  logic [XLEN-1:0]       W_valM,
    output logic [3:0]            d_srcA,
    output logic [3:0]            d_srcB,
    output logic [3:0]            E_stat,
    output logic [3:0]            E_icode,
    output logic [3:0]            E_ifun,
    output logic [3:0]            E_srcA,
    output logic [3:0]            E_srcB,
    output logic [3:0]            E_destE,
    output logic [3:0]            E_destM,
    output logic [XLEN-1:0]       E_valC,
    output logic [XLEN-1:0]       E_valA,
    output logic [XLEN-1:0]       E_valB,
    output logic [NREGS*XLEN-1:0] reg_flat
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]           perf_fwd_cnt,
    output logic [31:0]           perf_bubble_cnt
`endif
);

    localparam logic [3:0] RSP = 4'(RSP_ID);

    logic [3:0]      src_a, src_b, dst_e, dst_m;
    logic [XLEN-1:0] rf_a, rf_b;
    logic [XLEN-1:0] val_a, val_b;
    logic            fwd_a, fwd_b;
    d2e_ctl_t        e_ctl;
    logic [XLEN-1:0] e_valc_q, e_vala_q, e_valb_q;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            I_RRMOVQ: begin src_a = D_rA; dst_e = D_rB; end
            I_IRMOVQ: dst_e = D_rB;
            I_RMMOVQ: begin src_a = D_rA; src_b = D_rB; end
            I_MRMOVQ: begin src_b = D_rB; dst_m = D_rA; end
            I_OPQ:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
            I_CALL:   begin src_b = RSP; dst_e = RSP; end
            I_RET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            I_POPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA; end
            I_PUSHQ:  begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
            default:  ;
        endcase
    end

    assign d_srcA = src_a;
    assign d_srcB = src_b;

    y86_regfile #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .RSP_ID   (RSP_ID),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rd_a_id  (src_a),
        .rd_b_id  (src_b),
        .rd_a_val (rf_a),
        .rd_b_val (rf_b),
        .wr_e_id  (W_destE),
        .wr_e_val (W_valE),
        .wr_m_id  (W_destM),
        .wr_m_val (W_valM),
        .reg_flat (reg_flat)
    );

    // Youngest producer first; RNONE sources never match so they fall through to the 0 read.
    always_comb begin
        val_a = rf_a;
        fwd_a = 1'b0;
        if (D_icode == I_JXX || D_icode == I_CALL) begin
            val_a = D_valP;
        end else if (src_a != RNONE) begin
            fwd_a = 1'b1;
            if      (src_a == e_destE) val_a = e_valE;
            else if (src_a == M_destM) val_a = m_valM;
            else if (src_a == M_destE) val_a = M_valE;
            else if (src_a == W_destM) val_a = W_valM;
            else if (src_a == W_destE) val_a = W_valE;
            else                       fwd_a = 1'b0;
        end
    end

    always_comb begin
        val_b = rf_b;
        fwd_b = 1'b0;
        if (src_b != RNONE) begin
            fwd_b = 1'b1;
            if      (src_b == e_destE) val_b = e_valE;
            else if (src_b == M_destM) val_b = m_valM;
            else if (src_b == M_destE) val_b = M_valE;
            else if (src_b == W_destM) val_b = W_valM;
            else if (src_b == W_destE) val_b = W_valE;
            else                       fwd_b = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || E_bubble) begin
            e_ctl    <= BUBBLE_CTL;
            e_valc_q <= '0;
            e_vala_q <= '0;
            e_valb_q <= '0;
        end else if (!E_stall) begin
            e_ctl    <= '{stat: D_stat, icode: D_icode, ifun: D_ifun, srca: src_a,
                          srcb: src_b, deste: dst_e, destm: dst_m};
            e_valc_q <= D_valC;
            e_vala_q <= val_a;
            e_valb_q <= val_b;
        end
    end

    assign E_stat  = e_ctl.stat;
    assign E_icode = e_ctl.icode;
    assign E_ifun  = e_ctl.ifun;
    assign E_srcA  = e_ctl.srca;
    assign E_srcB  = e_ctl.srcb;
    assign E_destE = e_ctl.deste;
    assign E_destM = e_ctl.destm;
    assign E_valC  = e_valc_q;
    assign E_valA  = e_vala_q;
    assign E_valB  = e_valb_q;

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fwd_cnt    <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (!E_bubble && !E_stall && (fwd_a || fwd_b) && perf_fwd_cnt != 32'hFFFF_FFFF)
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            if (E_bubble && perf_bubble_cnt != 32'hFFFF_FFFF)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_y86_decode_wb_stage.sv
// Directed bench for y86_decode_wb_stage: a reference model of registers and forwarding checked every cycle.
module tb_y86_decode_wb_stage;
    import y86_pkg::*;

    localparam int XLEN  = 64;
    localparam int NREGS = 15;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [XLEN-1:0] D_valC, D_valP;
    logic E_stall, E_bubble;
    logic [3:0] e_destE, M_destE, M_destM, W_destE, W_destM;
    logic [XLEN-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0] d_srcA, d_srcB;
    logic [3:0] E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_destE, E_destM;
    logic [XLEN-1:0] E_valC, E_valA, E_valB;
    logic [NREGS*XLEN-1:0] reg_flat;
`ifdef DECODE_PERF_EN
    logic [31:0] perf_fwd_cnt, perf_bubble_cnt;
`endif

    y86_decode_wb_stage #(.XLEN(XLEN), .NREGS(NREGS), .RSP_ID(4), .RSP_INIT(200)) dut (
        .clk(clk), .rst(rst),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .e_destE(e_destE), .e_valE(e_valE),
        .M_destE(M_destE), .M_valE(M_valE),
        .M_destM(M_destM), .m_valM(m_valM),
        .W_destE(W_destE), .W_valE(W_valE),
        .W_destM(W_destM), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_destE(E_destE), .E_destM(E_destM),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .reg_flat(reg_flat)
`ifdef DECODE_PERF_EN
        , .perf_fwd_cnt(perf_fwd_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [XLEN-1:0] m_regs [NREGS];
    logic [3:0] m_stat, m_icode, m_ifun, m_srca, m_srcb, m_deste, m_destm;
    logic [XLEN-1:0] m_valc, m_vala, m_valb;
    logic [31:0] m_fwd, m_bub;
    bit model_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register usage per instruction class, written as a table of roles.
    function automatic void decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                   output logic [3:0] sa, output logic [3:0] sb,
                                   output logic [3:0] de, output logic [3:0] dm);
        sa = RNONE; sb = RNONE; de = RNONE; dm = RNONE;
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = ra;
        if (ic inside {4'h9, 4'hB})             sa = 4'd4;
        if (ic inside {4'h4, 4'h5, 4'h6})       sb = rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4'd4;
        if (ic inside {4'h2, 4'h3, 4'h6})       de = rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) de = 4'd4;
        if (ic == 4'h5 || ic == 4'hB)           dm = ra;
    endfunction

    function automatic logic [XLEN-1:0] rdreg(input logic [3:0] id);
        return (int'(id) < NREGS) ? m_regs[id] : '0;
    endfunction

    // Scan producers youngest to oldest; the first one naming the source supplies the value.
    task automatic pick(input logic [3:0] src, output logic [XLEN-1:0] v, output bit fwd);
        logic [3:0]      d [5];
        logic [XLEN-1:0] x [5];
        d[0] = e_destE; x[0] = e_valE;
        d[1] = M_destM; x[1] = m_valM;
        d[2] = M_destE; x[2] = M_valE;
        d[3] = W_destM; x[3] = W_valM;
        d[4] = W_destE; x[4] = W_valE;
        v = rdreg(src);
        fwd = 0;
        for (int i = 0; i < 5; i++) begin
            if (!fwd && src != RNONE && d[i] == src) begin
                v = x[i];
                fwd = 1;
            end
        end
    endtask

    task automatic model_bubble();
        m_stat = STAT_AOK; m_icode = I_NOP; m_ifun = 4'h0;
        m_srca = RNONE; m_srcb = RNONE; m_deste = RNONE; m_destm = RNONE;
        m_valc = '0; m_vala = '0; m_valb = '0;
    endtask

    // One clock: model predicts from inputs held across the edge, then updates after it.
    task automatic step();
        logic [3:0] sa, sb, de, dm;
        logic [XLEN-1:0] va, vb;
        bit fa, fb;
        decode(D_icode, D_rA, D_rB, sa, sb, de, dm);
        pick(sa, va, fa);
        pick(sb, vb, fb);
        if (D_icode == 4'h7 || D_icode == 4'h8) begin
            va = D_valP;
            fa = 0;
        end
        @(posedge clk);
        if (rst) begin
            model_bubble();
            for (int i = 0; i < NREGS; i++) m_regs[i] = (i == 4) ? 64'd200 : 64'd0;
            m_fwd = 0;
            m_bub = 0;
        end else begin
            if (E_bubble) model_bubble();
            else if (!E_stall) begin
                m_stat = D_stat; m_icode = D_icode; m_ifun = D_ifun;
                m_srca = sa; m_srcb = sb; m_deste = de; m_destm = dm;
                m_valc = D_valC; m_vala = va; m_valb = vb;
            end
            if (E_bubble && m_bub != 32'hFFFF_FFFF) m_bub++;
            if (!E_bubble && !E_stall && (fa || fb) && m_fwd != 32'hFFFF_FFFF) m_fwd++;
            if (int'(W_destE) < NREGS) m_regs[W_destE] = W_valE;
            if (int'(W_destM) < NREGS) m_regs[W_destM] = W_valM;
        end
        model_valid = 1;
        #1;
    endtask

    task automatic idle();
        rst = 0; E_stall = 0; E_bubble = 0;
        D_stat = STAT_AOK; D_icode = I_NOP; D_ifun = 0; D_rA = RNONE; D_rB = RNONE;
        D_valC = 0; D_valP = 0;
        e_destE = RNONE; M_destE = RNONE; M_destM = RNONE; W_destE = RNONE; W_destM = RNONE;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            logic [3:0] sa, sb, de, dm;
            decode(D_icode, D_rA, D_rB, sa, sb, de, dm);
            chk("d_srcA", 64'(d_srcA), 64'(sa));
            chk("d_srcB", 64'(d_srcB), 64'(sb));
            chk("E_stat", 64'(E_stat), 64'(m_stat));
            chk("E_icode", 64'(E_icode), 64'(m_icode));
            chk("E_ifun", 64'(E_ifun), 64'(m_ifun));
            chk("E_srcA", 64'(E_srcA), 64'(m_srca));
            chk("E_srcB", 64'(E_srcB), 64'(m_srcb));
            chk("E_destE", 64'(E_destE), 64'(m_deste));
            chk("E_destM", 64'(E_destM), 64'(m_destm));
            chk("E_valC", E_valC, m_valc);
            chk("E_valA", E_valA, m_vala);
            chk("E_valB", E_valB, m_valb);
            for (int i = 0; i < NREGS; i++) chk($sformatf("reg%0d", i), reg_flat[i*XLEN +: XLEN], m_regs[i]);
`ifdef DECODE_PERF_EN
            chk("perf_fwd_cnt", 64'(perf_fwd_cnt), 64'(m_fwd));
            chk("perf_bubble_cnt", 64'(perf_bubble_cnt), 64'(m_bub));
`endif
        end
    end

    initial begin
        idle();
        rst = 1;
        step();
        chk("rst E_icode", 64'(E_icode), 64'h1);
        chk("rst E_destE", 64'(E_destE), 64'hF);
        chk("rst reg4", reg_flat[4*XLEN +: XLEN], 64'd200);
        chk("rst reg0", reg_flat[0 +: XLEN], 64'd0);

        // W write to reg 3 forwarded into a same-cycle OPq
        idle(); W_destE = 3; W_valE = 7; D_icode = I_OPQ; D_rA = 3; D_rB = 5;
        step();
        chk("wfwd E_valA", E_valA, 64'd7);
        chk("wfwd E_destE", 64'(E_destE), 64'd5);
        chk("wfwd reg3", reg_flat[3*XLEN +: XLEN], 64'd7);

        // e beats M; valB reads the freshly written reg 3
        idle(); e_destE = 2; e_valE = 5; M_destE = 2; M_valE = 9;
        D_icode = I_RMMOVQ; D_rA = 2; D_rB = 3;
        step();
        chk("eprio E_valA", E_valA, 64'd5);
        chk("eprio E_valB", E_valB, 64'd7);

        idle(); W_destE = 4; W_valE = 100; W_destM = 4; W_valM = 55;
        step();
        chk("wm_wins reg4", reg_flat[4*XLEN +: XLEN], 64'd55);

        idle(); rst = 1; W_destE = 5; W_valE = 64'hDEAD;
        step();
        chk("rst_drops_write reg5", reg_flat[5*XLEN +: XLEN], 64'd0);

        idle(); D_icode = I_CALL; D_valP = 64'h40;
        step();
        chk("call E_valA", E_valA, 64'h40);
        chk("call E_valB", E_valB, 64'd200);
        chk("call E_destE", 64'(E_destE), 64'd4);

        idle(); D_icode = I_IRMOVQ; D_rB = 6; D_valC = 64'h1234;
        step();
        idle(); E_stall = 1; D_icode = I_OPQ; D_rA = 1; D_rB = 2; W_destE = 1; W_valE = 64'hAA;
        step();
        step();
        chk("stall E_icode", 64'(E_icode), 64'h3);
        chk("stall E_valC", E_valC, 64'h1234);
        chk("stall E_destE", 64'(E_destE), 64'd6);
        chk("stall_wb reg1", reg_flat[1*XLEN +: XLEN], 64'hAA);

        idle(); E_stall = 1; E_bubble = 1; D_icode = I_OPQ; D_rA = 1; D_rB = 2;
        step();
        chk("bubble E_icode", 64'(E_icode), 64'h1);
        chk("bubble E_stat", 64'(E_stat), 64'h8);
        chk("bubble E_valC", E_valC, 64'h0);
        chk("bubble E_destE", 64'(E_destE), 64'hF);
`ifdef DECODE_PERF_EN
        chk("bubble perf_bubble_cnt", 64'(perf_bubble_cnt), 64'd1);
`endif

        // m_valM beats W_valM on pop; pop also writes rsp via W this cycle
        idle(); D_icode = I_POPQ; D_rA = 7; M_destM = 4; m_valM = 64'h99; W_destM = 4; W_valM = 64'h77;
        step();
        chk("pop E_valA", E_valA, 64'h99);
        chk("pop E_valB", E_valB, 64'h99);
        chk("pop E_destM", 64'(E_destM), 64'd7);

        idle(); D_icode = I_PUSHQ; D_rA = 1; W_destE = 1; W_valE = 11; W_destM = 1; W_valM = 22;
        step();
        chk("push E_valA", E_valA, 64'd22);
        chk("push E_valB", E_valB, 64'h77);

        idle(); D_icode = I_JXX; D_valP = 64'h88; e_destE = 4; e_valE = 3;
        step();
        chk("jxx E_valA", E_valA, 64'h88);
        chk("jxx E_srcA", 64'(E_srcA), 64'hF);

        // Mixed traffic checked only against the model
        for (int n = 0; n < 48; n++) begin
            idle();
            D_stat   = 4'b0001 << $urandom_range(0, 3);
            D_icode  = 4'($urandom_range(0, 11));
            D_ifun   = 4'($urandom_range(0, 6));
            D_rA     = 4'($urandom_range(0, 15));
            D_rB     = 4'($urandom_range(0, 15));
            D_valC   = {$urandom, $urandom};
            D_valP   = {$urandom, $urandom};
            e_destE  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : RNONE;
            M_destE  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : RNONE;
            M_destM  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : RNONE;
            W_destE  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 14)) : RNONE;
            W_destM  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 14)) : RNONE;
            e_valE   = {$urandom, $urandom};
            M_valE   = {$urandom, $urandom};
            m_valM   = {$urandom, $urandom};
            W_valE   = {$urandom, $urandom};
            W_valM   = {$urandom, $urandom};
            E_stall  = ($urandom_range(0, 3) == 0);
            E_bubble = ($urandom_range(0, 7) == 0);
            step();
        end

        idle();
        step();
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_decode_wb_stage.md
# y86_decode_wb_stage

Parametrised decode/write-back stage for the Y-86 pipeline. Holds the architectural register file and decodes `D_icode` into source and destination register IDs. Forwards operands from the execute, memory and write-back stages, and produces the D→E pipeline register with stall and bubble control. It supersedes the fixed 64-bit, 15-register stage with configurable width and register count, a true synchronous reset, E-stage stall, and fixed forwarding priority.

## Interface
- `XLEN`, 64, data width of registers and values
- `NREGS`, 15, architectural registers; IDs 0..NREGS-1, `RNONE`=4'hF; NREGS ≤ 15
- `RSP_ID`, 4, stack-pointer register ID
- `RSP_INIT`, 200, reset value of register RSP_ID; all others reset to 0
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `D_stat` in 4: one-hot status; AOK=4'b1000
- `D_icode`, `D_ifun` in 4 each: decoded instruction fields
- `D_rA`, `D_rB` in 4 each: register specifiers
- `D_valC`, `D_valP` in XLEN each: constant and next PC
- `E_stall`, `E_bubble` in 1 each: hazard-control requests
- `e_destE` in 4, `e_valE` in XLEN: execute-stage forwarding source
- `M_destE` in 4, `M_valE` in XLEN: memory-stage ALU result
- `M_destM` in 4, `m_valM` in XLEN: memory-stage load data
- `W_destE` in 4, `W_valE` in XLEN: write-back port E
- `W_destM` in 4, `W_valM` in XLEN: write-back port M
- `d_srcA`, `d_srcB` out 4 each: combinational, to the hazard unit
- `E_stat`, `E_icode`, `E_ifun`, `E_srcA`, `E_srcB`, `E_destE`, `E_destM` out 4 each: D→E register
- `E_valC`, `E_valA`, `E_valB` out XLEN each: D→E register
- `reg_flat` out NREGS*XLEN: register i at bits [i*XLEN +: XLEN], combinational view of the array

## Operation
- Decode, default RNONE for all of srcA/srcB/destE/destM:
  - cmov (2): srcA=rA, destE=rB
  - irmov (3): destE=rB
  - rmmov (4): srcA=rA, srcB=rB
  - mrmov (5): srcB=rB, destM=rA
  - OPq (6): srcA=rA, srcB=rB, destE=rB
  - call (8): srcB=destE=RSP
  - ret (9) and pop (B): srcA=srcB=destE=RSP; pop also destM=rA
  - push (A): srcA=rA, srcB=destE=RSP
- valA select:
  - jXX (7) and call (8): valA=D_valP.
  - Otherwise first match wins: e_valE, m_valM, M_valE, W_valM, W_valE, then register file.
  - A match requires src==dest and dest≠RNONE.
- valB uses the same chain with no valP case.
- Source RNONE or ID ≥ NREGS reads 0.
- Write-back at posedge:
  - W_destE≠RNONE writes W_valE; W_destM≠RNONE writes W_valM.
  - When both name the same register, W_valM wins.
  - IDs ≥ NREGS are ignored. Writes are independent of W_icode.
- D→E register update priority: rst > E_bubble > E_stall > load.
  - Bubble: icode=1 (nop), ifun=0, stat=AOK, all IDs RNONE, all values 0.
  - Stall: hold all E_* registers.

## Timing
- Decode and forwarding are combinational. E_* registers update one cycle after D inputs are presented.
- Register write becomes visible in `reg_flat` and on the read path the cycle after the W edge. The same-cycle value reaches decode through the W forwarding legs.
- Reset, one cycle: E_* take bubble values, registers take 0/RSP_INIT, perf counters clear.
- Reset takes precedence over a simultaneous W write; that write is lost.
- E_bubble together with E_stall: bubble wins.
- Write-back continues during stall and bubble.

## Configuration
- `DECODE_PERF_EN` defined adds outputs `perf_fwd_cnt` and `perf_bubble_cnt`, 32-bit each, saturating at 2^32-1, cleared by rst.
  - `perf_fwd_cnt` increments once per loaded (not stalled, not bubbled) cycle in which valA or valB came from a forwarding leg.
  - `perf_bubble_cnt` increments per cycle with E_bubble=1.
- Undefined: these ports and logic are absent.

## Structure
- Package `y86_pkg` holds:
  - icode constants (`I_NOP`…`I_POPQ`)
  - `RNONE`
  - stat encodings (`STAT_AOK`, `STAT_HLT`, `STAT_ADR`, `STAT_INS`)
  - the bubble-value struct
- Sub-module `y86_regfile`: parametrised array, two combinational read ports, two write ports with M-over-E priority, synchronous reset, flat view output.

## Test plan
- rst high 1 cycle → E_icode=1, E_destE=F, reg 4=200, other registers 0, `reg_flat` matches.
- W_destE=3, W_valE=7 → next cycle reg 3=7. Same-cycle D OPq rA=3 → E_valA=7 via W forwarding.
- e_destE=2/valE=5 and M_destE=2/valE=9 both active, D rmmov rA=2 → E_valA=5 (e wins).
- W_destE=W_destM=4 with valE=100, valM=55 → reg 4=55.
- D call valP=0x40, reg 4=200 → E_valA=0x40, E_valB=200, E_destE=4.
- E_stall 2 cycles → E_* held. E_stall with E_bubble → nop. With `DECODE_PERF_EN`: bubble counter=1.
